// File: rtl/fetch_unit_pkg.sv
// Shared encodings for the fetch unit: opcodes, control-unit PC controls,
// FSM states and the internal next-pc select.
package fetch_unit_pkg;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_IN   = 5'b00111;
    localparam logic [4:0] OP_STOP = 5'b11111;

    typedef enum logic [1:0] {
        CNT_INC  = 2'b00,
        CNT_LOAD = 2'b01,
        CNT_RSVD = 2'b10,
        CNT_HALT = 2'b11
    } counter_e;

    typedef enum logic [1:0] {
        MUX_IMM   = 2'b00,
        MUX_REG_J = 2'b01,
        MUX_REG_B = 2'b10,
        MUX_HOLD  = 2'b11
    } mult_e;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_LATCH,
        ST_EXEC,
        ST_WAIT_IN,
        ST_HALT
    } state_e;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_INC,
        PC_IMM,
        PC_REG
    } pc_sel_e;

endpackage

// File: rtl/fetch_unit_pc_register.sv
// Program counter register: applies the next-pc select chosen by the fetch FSM.
module fetch_unit_pc_register
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  pc_sel_e           sel,
    input  logic [ADDR_W-1:0] target_imm,
    input  logic [DATA_W-1:0] target_reg,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_next;

    // Register targets wider than the ROM address space are truncated.
    logic unused_reg_upper;
    assign unused_reg_upper = ^target_reg[DATA_W-1:ADDR_W];

    always_comb begin
        pc_next = pc;
        case (sel)
            PC_INC:  pc_next = pc + ADDR_W'(1);
            PC_IMM:  pc_next = target_imm;
            PC_REG:  pc_next = target_reg[ADDR_W-1:0];
            default: pc_next = pc;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= '0;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: FETCH/LATCH/EXEC per instruction, IN-stall
// handshake, STOP halt, and the one-cycle execute strobe.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic [DATA_W-1:0] instr,
    output logic [4:0]        opcode,
    input  logic [1:0]        UC_counter,
    input  logic [1:0]        UC_mult03,
    input  logic              UC_clock,
    input  logic [ADDR_W-1:0] target_imm,
    input  logic [DATA_W-1:0] target_reg,
    input  logic              in_valid,
    output logic              in_ack,
    output logic              exec_en,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    state_e  state;
    pc_sel_e pc_sel;
    logic    run;
    logic    accept;

    // run: normal commit in EXEC; accept: input consumed, from EXEC or WAIT_IN.
    always_comb begin
        run    = 1'b0;
        accept = 1'b0;
        if (!reset) begin
            run    = (state == ST_EXEC) && UC_clock;
            accept = in_valid && (((state == ST_EXEC) && !UC_clock) ||
                                  (state == ST_WAIT_IN));
        end
        exec_en = run || accept;
        in_ack  = accept;

        pc_sel = PC_HOLD;
        if (accept) begin
            pc_sel = PC_INC;
        end else if (run) begin
            case (counter_e'(UC_counter))
                CNT_INC, CNT_RSVD: pc_sel = PC_INC;
                CNT_LOAD: begin
                    case (mult_e'(UC_mult03))
                        MUX_IMM:              pc_sel = PC_IMM;
                        MUX_REG_J, MUX_REG_B: pc_sel = PC_REG;
                        default:              pc_sel = PC_HOLD;
                    endcase
                end
                default: pc_sel = PC_HOLD;
            endcase
        end
    end

    assign imem_addr = pc;
    assign opcode    = instr[31:27];

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_FETCH;
            instr  <= '0;
            halted <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: state <= ST_LATCH;
                ST_LATCH: begin
                    instr <= imem_data;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (accept) begin
                        state <= ST_FETCH;
                    end else if (!UC_clock) begin
                        state <= ST_WAIT_IN;
                    end else if (counter_e'(UC_counter) == CNT_HALT) begin
                        halted <= 1'b1;
                        state  <= ST_HALT;
                    end else begin
                        state <= ST_FETCH;
                    end
                end
                ST_WAIT_IN: begin
                    if (accept) begin
                        state <= ST_FETCH;
                    end
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_FETCH;
            endcase
        end
    end

    fetch_unit_pc_register #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_pc_register (
        .clock      (clock),
        .reset      (reset),
        .sel        (pc_sel),
        .target_imm (target_imm),
        .target_reg (target_reg),
        .pc         (pc)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: instruction-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic [DATA_W-1:0] instr;
    logic [4:0]        opcode;
    logic [1:0]        UC_counter;
    logic [1:0]        UC_mult03;
    logic              UC_clock;
    logic [ADDR_W-1:0] target_imm;
    logic [DATA_W-1:0] target_reg;
    logic              in_valid;
    logic              in_ack;
    logic              exec_en;
    logic [ADDR_W-1:0] pc;
    logic              halted;

    fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .instr      (instr),
        .opcode     (opcode),
        .UC_counter (UC_counter),
        .UC_mult03  (UC_mult03),
        .UC_clock   (UC_clock),
        .target_imm (target_imm),
        .target_reg (target_reg),
        .in_valid   (in_valid),
        .in_ack     (in_ack),
        .exec_en    (exec_en),
        .pc         (pc),
        .halted     (halted)
    );

    always #5 clock = ~clock;

    // Synchronous ROM and the per-address control-unit responses
    logic [31:0] rom   [0:1023];
    logic [1:0]  t_cnt [0:1023];
    logic [1:0]  t_mux [0:1023];
    logic        t_clk [0:1023];
    logic [9:0]  t_imm [0:1023];
    logic [31:0] t_reg [0:1023];

    always_ff @(posedge clock) imem_data <= rom[imem_addr];

    // Reference model: slot within instruction (0 fetch, 1 latch, 2 exec, 3 stalled, 4 halted)
    int          m_slot;
    logic [9:0]  m_pc;
    logic [31:0] m_instr;
    logic        m_halted;

    logic rst_drv, iv_drv, prev_exec;
    int   n_checks, n_fail;

    logic [9:0] cur_addr, cur_pc;
    logic [31:0] cur_instr;
    logic [4:0] cur_opcode;
    logic cur_exec, cur_ack, cur_halted;

    logic [9:0] a [0:31];
    logic       e [0:31];
    logic [4:0] o [0:31];
    int         cnt_exec, cnt_ack;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic init_tables();
        for (int i = 0; i < 1024; i++) begin
            rom[i]   = {OP_ADD, 27'(i)};
            t_cnt[i] = 2'b00;
            t_mux[i] = 2'($urandom);
            t_clk[i] = 1'b1;
            t_imm[i] = 10'($urandom);
            t_reg[i] = $urandom;
        end
    endtask

    task automatic step();
        logic commit, ack_req;
        @(negedge clock);
        reset    = rst_drv;
        in_valid = iv_drv;
        if (m_slot == 2) begin
            UC_counter = t_cnt[m_pc];
            UC_mult03  = t_mux[m_pc];
            UC_clock   = t_clk[m_pc];
            target_imm = t_imm[m_pc];
            target_reg = t_reg[m_pc];
        end else begin
            UC_counter = 2'($urandom);
            UC_mult03  = 2'($urandom);
            UC_clock   = 1'($urandom);
            target_imm = 10'($urandom);
            target_reg = $urandom;
        end
        #1;
        commit  = !rst_drv && ((m_slot == 2 && (UC_clock || iv_drv)) || (m_slot == 3 && iv_drv));
        ack_req = commit && (m_slot == 3 || !UC_clock);
        check("imem_addr", 32'(imem_addr), 32'(m_pc));
        check("pc", 32'(pc), 32'(m_pc));
        check("instr", instr, m_instr);
        check("opcode", 32'(opcode), 32'(m_instr[31:27]));
        check("exec_en", 32'(exec_en), 32'(commit));
        check("in_ack", 32'(in_ack), 32'(ack_req));
        check("halted", 32'(halted), 32'(m_halted));
        check("exec_back_to_back", 32'(prev_exec & exec_en), 32'd0);
        prev_exec  = exec_en;
        cur_addr   = imem_addr;
        cur_pc     = pc;
        cur_instr  = instr;
        cur_opcode = opcode;
        cur_exec   = exec_en;
        cur_ack    = in_ack;
        cur_halted = halted;
        @(posedge clock);
        if (rst_drv) begin
            m_slot = 0; m_pc = '0; m_instr = '0; m_halted = 1'b0;
        end else begin
            case (m_slot)
                0: m_slot = 1;
                1: begin m_instr = rom[m_pc]; m_slot = 2; end
                2: begin
                    if (!UC_clock) begin
                        if (iv_drv) begin m_pc = m_pc + 10'd1; m_slot = 0; end
                        else m_slot = 3;
                    end else begin
                        m_slot = 0;
                        case (UC_counter)
                            2'b01: begin
                                if (UC_mult03 == 2'b00)      m_pc = target_imm;
                                else if (UC_mult03 != 2'b11) m_pc = target_reg[9:0];
                            end
                            2'b11: begin m_halted = 1'b1; m_slot = 4; end
                            default: m_pc = m_pc + 10'd1;
                        endcase
                    end
                end
                3: if (iv_drv) begin m_pc = m_pc + 10'd1; m_slot = 0; end
                default: ;
            endcase
        end
    endtask

    task automatic do_reset();
        rst_drv = 1'b1;
        step();
        rst_drv = 1'b0;
    endtask

    task automatic run(input int n);
        cnt_exec = 0;
        cnt_ack  = 0;
        for (int c = 0; c < n; c++) begin
            step();
            a[c] = cur_addr;
            e[c] = cur_exec;
            o[c] = cur_opcode;
            cnt_exec += int'(cur_exec);
            cnt_ack  += int'(cur_ack);
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; prev_exec = 1'b0;
        rst_drv = 1'b1; iv_drv = 1'b0;
        reset = 1'b1; in_valid = 1'b0;
        UC_counter = '0; UC_mult03 = '0; UC_clock = 1'b1;
        target_imm = '0; target_reg = '0;
        init_tables();
        repeat (2) @(posedge clock);
        m_slot = 0; m_pc = '0; m_instr = '0; m_halted = 1'b0;
        do_reset();

        // Straight-line adds
        step();
        check("reset_instr", cur_instr, 32'd0);
        check("reset_halted", 32'(cur_halted), 32'd0);
        check("reset_exec", 32'(cur_exec), 32'd0);
        run(8);
        check("seq_addr_c3", 32'(a[2]), 32'd1);
        check("seq_addr_c6", 32'(a[5]), 32'd2);
        check("seq_exec_c2", 32'(e[1]), 32'd1);
        check("seq_exec_c5", 32'(e[4]), 32'd1);
        check("seq_exec_c8", 32'(e[7]), 32'd1);
        check("seq_opcode_c2", 32'(o[1]), 32'(5'b00001));
        check("seq_exec_count", 32'(cnt_exec), 32'd3);

        // jumpi at address 1 to 0x005
        init_tables();
        t_cnt[1] = 2'b01; t_mux[1] = 2'b00; t_imm[1] = 10'h005;
        do_reset();
        run(7);
        check("jumpi_addr_c3", 32'(a[3]), 32'd1);
        check("jumpi_addr_c6", 32'(a[6]), 32'd5);
        check("jumpi_exec_once", 32'(int'(e[3]) + int'(e[4]) + int'(e[5])), 32'd1);

        // Register jump with upper bits set, then hold
        init_tables();
        t_cnt[0] = 2'b01; t_mux[0] = 2'b01; t_reg[0] = 32'h0000_0403;
        t_cnt[3] = 2'b01; t_mux[3] = 2'b11;
        do_reset();
        run(9);
        check("regjump_addr_c3", 32'(a[3]), 32'h003);
        check("hold_addr_c6", 32'(a[6]), 32'h003);
        check("hold_pc_c8", 32'(cur_pc), 32'h003);

        // IN stall, acceptance from WAIT_IN, acceptance in EXEC, reset in WAIT_IN
        init_tables();
        rom[0] = {OP_IN, 27'd0}; t_clk[0] = 1'b0;
        rom[1] = {OP_IN, 27'd1}; t_clk[1] = 1'b0;
        rom[2] = {OP_IN, 27'd2}; t_clk[2] = 1'b0;
        iv_drv = 1'b0;
        do_reset();
        run(3);
        check("stall_exec_first", 32'(cnt_exec), 32'd0);
        run(10);
        check("stall_exec_count", 32'(cnt_exec), 32'd0);
        check("stall_ack_count", 32'(cnt_ack), 32'd0);
        check("stall_pc_hold", 32'(cur_pc), 32'd0);
        iv_drv = 1'b1;
        step();
        check("accept_exec", 32'(cur_exec), 32'd1);
        check("accept_ack", 32'(cur_ack), 32'd1);
        iv_drv = 1'b0;
        step();
        check("accept_pc_inc", 32'(cur_pc), 32'd1);
        iv_drv = 1'b1;
        run(2);
        check("exec_accept_exec", 32'(e[1]), 32'd1);
        check("exec_accept_ack", 32'(cnt_ack), 32'd1);
        iv_drv = 1'b0;
        run(5);
        check("wait2_pc", 32'(cur_pc), 32'd2);
        rst_drv = 1'b1; iv_drv = 1'b1;
        step();
        check("reset_in_wait_ack", 32'(cur_ack), 32'd0);
        rst_drv = 1'b0; iv_drv = 1'b0;
        step();
        check("reset_in_wait_pc", 32'(cur_pc), 32'd0);
        run(2);

        // STOP at address 4
        init_tables();
        rom[4] = {OP_STOP, 27'd4}; t_cnt[4] = 2'b11;
        do_reset();
        run(15);
        check("stop_exec_c14", 32'(e[14]), 32'd1);
        check("stop_opcode", 32'(o[14]), 32'(5'b11111));
        step();
        check("halted_set", 32'(cur_halted), 32'd1);
        check("halt_addr", 32'(cur_addr), 32'd4);
        cnt_exec = 0;
        for (int c = 0; c < 20; c++) begin
            iv_drv = c[0];
            step();
            cnt_exec += int'(cur_exec);
        end
        iv_drv = 1'b0;
        check("halt_exec_count", 32'(cnt_exec), 32'd0);
        check("halt_addr_held", 32'(cur_addr), 32'd4);
        do_reset();
        step();
        check("halt_reset_halted", 32'(cur_halted), 32'd0);
        check("halt_reset_pc", 32'(cur_pc), 32'd0);

        // PC wrap
        init_tables();
        t_cnt[0] = 2'b01; t_mux[0] = 2'b00; t_imm[0] = 10'd1023;
        do_reset();
        run(7);
        check("wrap_addr_c3", 32'(a[3]), 32'd1023);
        check("wrap_addr_c6", 32'(a[6]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch and program-counter block that produces the opcode consumed by the control unit.
- Reads the control unit's PC-update controls (UC_counter, UC_mult03, UC_clock) and the jump/branch targets, and sequences each instruction through fetch, latch and execute.
- Drives the synchronous instruction ROM.
- Provides the one-cycle execute strobe that gates register-file and data-memory writes.
- Owns the IN-instruction stall handshake and the STOP halt state.

Parameters:
- ADDR_W, 10, PC and instruction-ROM address width.
- DATA_W, 32, instruction word and register target width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  ADDR_W  instruction ROM address; ROM data is valid one cycle after the address.
- imem_data  in  DATA_W  instruction ROM read data.
- instr  out  DATA_W  latched current instruction.
- opcode  out  5  instr[31:27], routed to the control unit.
- UC_counter  in  2  PC action: 00 increment, 01 load target, 10 reserved (treated as increment), 11 halt.
- UC_mult03  in  2  target select: 00 target_imm, 01 or 10 target_reg, 11 hold (PC unchanged).
- UC_clock  in  1  0 means the instruction needs external input and must stall.
- target_imm  in  ADDR_W  immediate jump target from the instruction field.
- target_reg  in  DATA_W  register jump/branch target.
- in_valid  in  1  external input data is available.
- in_ack  out  1  one-cycle pulse; the input was consumed.
- exec_en  out  1  one-cycle commit strobe for the current instruction.
- pc  out  ADDR_W  current program counter.
- halted  out  1  high after STOP executes.

Behaviour:
- FSM states: FETCH, LATCH, EXEC, WAIT_IN, HALT.
- Reset values: state FETCH; pc 0; instr 0 (opcode 00000, the control unit's default no-op); exec_en, in_ack and halted 0. Reset overrides every state, including WAIT_IN and HALT.
- imem_addr equals pc in all states (combinational).
- FETCH: address is presented. Next state is LATCH.
- LATCH: instr is loaded from imem_data at the clock edge. Next state is EXEC.
- EXEC: instr and opcode are stable; control inputs are sampled.
  - If UC_clock is 0 and in_valid is 0: exec_en is 0 and the next state is WAIT_IN.
  - If UC_clock is 0 and in_valid is 1: same as WAIT_IN acceptance (below), in the same cycle.
  - Otherwise: exec_en is 1 for this cycle, and the PC updates at the edge as follows.
    - UC_counter 00 or 10: pc becomes pc+1, modulo 2^ADDR_W.
    - UC_counter 01, UC_mult03 00: pc becomes target_imm.
    - UC_counter 01, UC_mult03 01 or 10: pc becomes target_reg[ADDR_W-1:0]; upper bits are ignored.
    - UC_counter 01, UC_mult03 11: pc is unchanged.
    - UC_counter 11: pc is unchanged, halted is set, and the next state is HALT.
  - Next state is FETCH for every case except the halt.
- WAIT_IN: exec_en is 0 and pc holds for as long as in_valid is 0.
  - On the first cycle with in_valid 1: exec_en and in_ack are both 1 for exactly one cycle.
  - At that edge pc becomes pc+1 and the next state is FETCH.
  - UC_counter is ignored for stalled instructions.
- HALT: exec_en is 0, pc is frozen, halted stays 1, and imem_addr is held. Only reset exits this state.
- Latency: 3 cycles per instruction, plus the stall cycles spent in WAIT_IN.
- exec_en is never high for two consecutive cycles.
- in_ack is high only together with exec_en.
- Inputs that change outside EXEC and WAIT_IN have no effect.
- PC wrap: incrementing from 2^ADDR_W-1 gives 0, with no flag.

Decomposition:
- Shared package holds:
  - the opcode constants (add 00001 through stop 11111, including in 00111);
  - the UC_counter encodings INC, LOAD, RSVD, HALT;
  - the UC_mult03 encodings IMM, REG_J, REG_B, HOLD;
  - the FSM state typedef.
- One natural sub-module, pc_register: holds pc and applies the next-pc select and the truncation.
- FSM and handshake logic stay in fetch_unit.

Test Plan:
- Reset, then a ROM of three add instructions with UC_counter 00 -> imem_addr is 0, 1, 2 at cycles 0, 3, 6; exec_en is high at cycles 2, 5, 8; opcode is 00001 during EXEC.
- jumpi at address 1 (UC_counter 01, UC_mult03 00, target_imm 0x005) -> the next FETCH has imem_addr 5 and exec_en pulses once.
- jump via register (UC_mult03 01, target_reg 0x0000_0403, ADDR_W 10) -> pc is 0x003. Repeat with UC_mult03 11 -> pc is unchanged and the same address is refetched.
- IN stall: UC_clock 0 with in_valid low for 10 cycles -> exec_en and in_ack stay 0 and pc holds. Then in_valid goes high -> exec_en and in_ack are 1 for one cycle and pc becomes pc+1. Reset asserted during WAIT_IN -> pc 0, state FETCH, no in_ack.
- STOP at address 4 (UC_counter 11) -> halted is 1 from the next cycle and imem_addr stays 4. exec_en stays 0 for 20 cycles even with in_valid toggling. Reset -> halted 0, pc 0.
- Wrap: pc preloaded to 1023 by a jumpi, then an add with UC_counter 00 -> the next imem_addr is 0.
